// File: rtl/pipe_arbiter.sv
// pipe_arbiter: round-robin sharing of one fixed-latency, non-stallable pipelined unit among NUM_REQ requesters.
// Optional grant/stall statistics counters are built when PIPE_ARBITER_STATS_EN is defined.
module pipe_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 32,
   parameter int LATENCY   = 4,
   parameter int IDW       = $clog2(NUM_REQ),
   parameter int CW        = $clog2(LATENCY + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     unit_valid,
   output logic [WIDTH-1:0]         unit_data,
   input  logic [OUT_WIDTH-1:0]     unit_result,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [OUT_WIDTH-1:0]     resp_data,
   input  logic                     drain_req,
   output logic                     drained,
   output logic [CW-1:0]            inflight,
   output logic [NUM_REQ*32-1:0]    stat_grants,
   output logic [31:0]              stat_stall
);

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_DRAIN   = 2'd1;
   localparam logic [1:0] S_DRAINED = 2'd2;

   logic [1:0]     r_state;
   logic [IDW-1:0] r_ptr;
   logic [CW-1:0]  r_inflight;
   logic           r_tag_vld_p [LATENCY];
   logic [IDW-1:0] r_tag_id_p  [LATENCY];

   logic           w_issue_en;
   logic           w_found;
   logic           w_issue;
   logic           w_retire;
   logic [IDW-1:0] w_winner;

   // Round-robin scan starting at the pointer; first valid requester wins.
   always_comb begin
      int w_idx;
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (!w_found && req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = IDW'(w_idx);
         end
      end
   end

   assign w_issue_en = (r_state == S_RUN) && !drain_req && !rst;
   assign req_ready  = (w_issue_en && w_found) ? (NUM_REQ'(1) << w_winner) : '0;
   assign w_issue    = |(req_valid & req_ready);
   assign unit_valid = w_issue;
   assign unit_data  = w_issue ? req_data[w_winner*WIDTH +: WIDTH] : '0;

   // Tags issued before a reset must never surface, even during the reset cycle itself.
   assign resp_valid = (r_tag_vld_p[LATENCY-1] && !rst) ? (NUM_REQ'(1) << r_tag_id_p[LATENCY-1]) : '0;
   assign resp_data  = unit_result;
   assign w_retire   = |resp_valid;
   assign drained    = (r_state == S_DRAINED) && !rst;
   assign inflight   = r_inflight;

   // Stage boundary: control state, in-flight count and tag valids
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_ptr      <= '0;
         r_inflight <= '0;
         for (int k = 0; k < LATENCY; k++) r_tag_vld_p[k] <= 1'b0;
      end else begin
         if (w_issue) r_ptr <= (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
         if (w_issue && !w_retire)      r_inflight <= r_inflight + 1'b1;
         else if (!w_issue && w_retire) r_inflight <= r_inflight - 1'b1;
         r_tag_vld_p[0] <= w_issue;
         for (int k = 1; k < LATENCY; k++) r_tag_vld_p[k] <= r_tag_vld_p[k-1];
         case (r_state)
            S_RUN:     if (drain_req) r_state <= S_DRAIN;
            S_DRAIN:   if (!drain_req) r_state <= S_RUN;
                       else if (r_inflight == '0) r_state <= S_DRAINED;
            S_DRAINED: if (!drain_req) r_state <= S_RUN;
            default:   r_state <= S_RUN;
         endcase
      end
   end

   // Stage boundary: tag ids travel alongside their valids
   always_ff @(posedge clk) begin
      r_tag_id_p[0] <= w_winner;
      for (int k = 1; k < LATENCY; k++) r_tag_id_p[k] <= r_tag_id_p[k-1];
   end

`ifdef PIPE_ARBITER_STATS_EN
   logic [31:0] r_grant_cnt [NUM_REQ];
   logic [31:0] r_stall_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
         r_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i]) r_grant_cnt[i] <= sat_inc(r_grant_cnt[i]);
         if (|req_valid && !w_issue) r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = r_grant_cnt[i];
   end
   assign stat_stall = r_stall_cnt;
`else
   assign stat_grants = '0;
   assign stat_stall  = '0;
`endif

endmodule

// File: doc/pipe_arbiter.md
Name: pipe_arbiter

Overview:
- Round-robin arbiter that shares one fixed-latency, non-stallable pipelined unit (divider, interpolator and similar) between NUM_REQ requesters in the render datapath.
- Issues at most one operation per cycle to the unit.
- Carries a {valid, id} tag down an internal delay line of LENGTH LATENCY and steers each result back to the requester that issued it.
- Provides a drain handshake so upstream control can quiesce the unit, for example before a mode switch.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥ 2.
- WIDTH, 32: operand width per request.
- OUT_WIDTH, 32: result width returned by the unit.
- LATENCY, 4: unit latency in cycles, from issue edge to result; must be ≥ 1.
- IDW, $clog2(NUM_REQ): requester id width (derived; do not override).
- CW, $clog2(LATENCY+1): in-flight counter width (derived).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, NUM_REQ: per-requester request valid.
- req_data, input, NUM_REQ×WIDTH: per-requester operand.
- req_ready, output, NUM_REQ: one-hot grant; the request is accepted on an edge where valid and ready are both high.
- unit_valid, output, 1: operand issued to the unit this cycle.
- unit_data, output, WIDTH: operand to the unit.
- unit_result, input, OUT_WIDTH: unit output, valid exactly LATENCY cycles after the matching issue.
- resp_valid, output, NUM_REQ: one-hot result strobe to the owning requester.
- resp_data, output, OUT_WIDTH: equals unit_result (combinational pass-through).
- drain_req, input, 1: request to stop issuing and empty the unit.
- drained, output, 1: unit is empty and issue is blocked.
- inflight, output, CW: number of operations currently inside the unit.
- stat_grants, output, NUM_REQ×32: grant counters (see Optional Feature).
- stat_stall, output, 32: stall counter (see Optional Feature).

Behaviour:
- Reset:
  - rr pointer = 0; tag line cleared; inflight = 0; FSM = RUN.
  - Outputs in the reset cycle: req_ready = 0, unit_valid = 0, resp_valid = 0, drained = 0.
- Issue enable: issue_en = (state == RUN) && !drain_req && !rst.
- Arbitration (combinational):
  - Scan requesters starting at ptr, wrapping modulo NUM_REQ; the first asserted req_valid[i] wins.
  - req_ready = onehot(i) when issue_en and any req_valid is high, else 0.
  - req_ready never depends on req_valid of a losing requester.
- Issue:
  - unit_valid = |(req_valid & req_ready).
  - unit_data = req_data[winner] when unit_valid, else 0.
- Pointer update:
  - On an issue edge, ptr ← (winner + 1) mod NUM_REQ.
  - With no issue, ptr holds.
  - Wrap: a grant to NUM_REQ−1 sets ptr = 0.
- Tag line:
  - tag[0] ← {unit_valid, winner}; tag[k+1] ← tag[k] for k < LATENCY−1.
  - resp_valid = tag[LATENCY−1].valid ? onehot(tag[LATENCY−1].id) : 0.
  - Result-to-strobe alignment is exact: an issue at edge e gives a resp_valid pulse during the cycle after edge e+LATENCY−1.
  - No response backpressure; requesters must accept every resp_valid.
- inflight:
  - +1 on issue, −1 on retire (resp_valid non-zero); unchanged when both or neither occur.
  - Never exceeds LATENCY and never underflows.
- FSM:
  - RUN: drain_req=1 → DRAIN. Grants are already blocked combinationally in that cycle.
  - DRAIN: drain_req=0 → RUN. Otherwise inflight==0 → DRAINED. In-flight results still retire normally.
  - DRAINED: drained=1; drain_req=0 → RUN, and issue resumes on the following cycle.
- Boundary cases:
  - Drain with an empty unit: RUN → DRAIN → DRAINED; drained rises 2 cycles after drain_req rises.
  - Reset mid-operation: all in-flight tags are discarded, and no resp_valid is produced for operations issued before reset even though unit_result may still carry data.
  - Only one requester valid: it is granted every cycle at 100% throughput.
  - Requester drops req_valid without a grant: legal; no state change.

Optional Feature:
- Macro: PIPE_ARBITER_STATS_EN.
- Defined:
  - stat_grants[i] increments on each grant to requester i.
  - stat_stall increments each cycle with |req_valid high and unit_valid low.
  - Both counters are 32-bit, saturate at 0xFFFF_FFFF and clear on rst.
- Undefined: counters are not built; stat_grants and stat_stall are tied to 0.

Test Plan:
- All 4 requesters valid continuously from reset, LATENCY=4:
  - Grants run 0,1,2,3,0,…
  - resp_valid follows each grant exactly 4 cycles later with the same id.
  - inflight steadies at 4.
- Only requester 2 valid for 10 cycles: 10 consecutive grants to 2; ptr = 3 afterwards.
- Drain asserted with inflight=3:
  - req_ready = 0 from that cycle.
  - 3 more resp_valid pulses, then drained = 1 once inflight = 0.
  - Release drain_req → grants resume next cycle.
- Drain asserted with inflight=0: drained = 1 two cycles later.
- rst pulsed for one cycle with inflight=4: no resp_valid pulses afterwards; inflight = 0; next grant goes to requester 0 (ptr reset).
- With PIPE_ARBITER_STATS_EN defined:
  - 8 cycles with all requesters valid → stat_grants = {2,2,2,2}.
  - 5 cycles valid during drain → stat_stall = 5.
